btn_debounce_pulse: RTL and testbench
=====================================

// Module: btn_debounce_pulse
// PURPOSE
//  Upstream conditioning stage for the traffic-light RGB LED controller's btn[3:0] inputs.
//  Synchronises raw push-buttons, debounces them on a slow sample tick, and emits one-clk press pulses.
//  The controller counts every high cycle of btn as a press event, so it needs clean single-cycle events.
//  Also exports the debounced levels for status LEDs.
// PARAMETERS
//  N_BTN         4            number of button channels
//  CLK_HZ        100_000_000  clk frequency
//  SAMPLE_HZ     1_000        debounce sample rate; TICK_DIV = CLK_HZ/SAMPLE_HZ (integer, >=2)
//  STABLE_CNT    20           consecutive disagreeing samples needed to change level (1..255)
//  REPEAT_DELAY  500          samples held before first auto-repeat (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD 100          samples between auto-repeats (AUTO_REPEAT_EN only)
// PORTS
//  clk        in   1      system clock, 100MHz
//  rst_n      in   1      synchronous active-low reset
//  btn_raw    in   N_BTN  asynchronous raw button inputs, active-high
//  btn_level  out  N_BTN  debounced level per button
//  btn_pulse  out  N_BTN  one-clk pulse per accepted press (and per repeat)
//  tick       out  1      sample strobe, 1 clk wide; for observation and test
// BEHAVIOUR
//  Reset: one clock, single reset domain (clk, rst_n). Reset is synchronous and active-low:
//   sampled only on posedge clk with rst_n==0.
//   During reset: btn_level=0, btn_pulse=0, tick=0, tick counter=0, all channel FSMs in IDLE,
//   all channel counters=0, synchroniser flops=0.
//   Reset asserted mid-debounce or mid-hold drops the event; no pulse is emitted on exit.
//  Synchroniser: 2-FF per bit; sync = btn_raw delayed 2 clk.
//  Tick generator:
//   - tick_cnt counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for the cycle in which tick_cnt==TICK_DIV-1.
//   - First tick occurs TICK_DIV cycles after reset release.
//  Per-channel FSM, evaluated only on tick:
//   IDLE:   sync==1 -> PRESS_WAIT, cnt=1.
//   PRESS_WAIT:
//    - sync==0 -> IDLE, cnt=0.
//    - cnt==STABLE_CNT-1 and sync==1 -> PRESSED: level<=1, pulse, cnt=0.
//    - otherwise cnt++.
//   PRESSED: sync==0 -> RELEASE_WAIT, cnt=1; else hold.
//   RELEASE_WAIT:
//    - sync==1 -> PRESSED, cnt=0.
//    - cnt==STABLE_CNT-1 and sync==0 -> IDLE: level<=0, cnt=0.
//    - otherwise cnt++.
//   STABLE_CNT==1: the first agreeing sample accepts immediately (IDLE->PRESSED).
//  Pulse timing:
//   - btn_pulse[i] is registered and high for exactly one clk, the cycle after the accepting tick.
//   - btn_level[i] rises in that same cycle.
//   - No pulse on release.
//   - Pulse never exceeds 1 clk, independent of hold time.
//  Channels are fully independent; simultaneous presses give simultaneous pulses.
//  Counter width: $clog2(STABLE_CNT+1) for cnt; saturation not needed (state bounds it).
//  Latency: raw edge to pulse = 2 clk sync + wait to next tick + (STABLE_CNT-1) ticks + 1 clk.
// CONFIGURATION
//  `define BTN_AUTO_REPEAT_EN:
//   - PRESSED keeps a hold counter (cleared on entry).
//   - After REPEAT_DELAY ticks held, one extra pulse; then one every REPEAT_PERIOD ticks.
//   - Stops immediately on entering RELEASE_WAIT; resumes counting from 0 if it returns to PRESSED.
//  Without the macro: the hold counter is absent; exactly one pulse per accepted press.
// STRUCTURE
//  Package btn_pkg:
//   - FSM state typedef (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
//   - Width helper constants.
//  Sub-module btn_debounce_ch: synchroniser + FSM + pulse/repeat logic for one bit.
//   Instantiated N_BTN times via generate.
//  Top: shared tick generator and output concatenation only.
// TESTING (bench params: CLK_HZ=1000, SAMPLE_HZ=100 -> TICK_DIV=10; STABLE_CNT=4;
//  REPEAT_DELAY=6, REPEAT_PERIOD=3)
//  1 Reset: hold rst_n=0 5 clk with btn_raw=4'hF -> all outputs 0.
//    Release -> first tick at cycle 10.
//  2 Clean press: btn_raw[0] 0->1 held -> exactly one btn_pulse[0] 1-clk wide,
//    the cycle after the 4th tick sampling 1.
//    btn_level[0]=1; release 4 ticks -> level 0, no pulse.
//  3 Bounce: btn_raw[1] toggles every 7 clk for 60 clk, then settles 1
//    -> zero pulses during bounce, one pulse after 4 stable ticks.
//  4 Glitch: btn_raw[2]=1 for 3 ticks then 0 -> no pulse, level stays 0.
//    Drop to 0 for 2 ticks while PRESSED -> level stays 1, no second pulse.
//  5 Simultaneous: btn_raw=4'b1100 same cycle -> btn_pulse==4'b1100 in one cycle.
//    Also: rst_n=0 during PRESS_WAIT -> no pulse after release of reset until a fresh 4-tick press.
//  6 BTN_AUTO_REPEAT_EN: hold btn_raw[3] 20 ticks after acceptance
//    -> pulses at acceptance, +6, +9, +12, +15, +18 ticks.
//    Without the macro -> only the acceptance pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and width helpers for the button debounce slice.
//   btn_state_e  per-channel debounce FSM state
//   width_for()  counter width able to hold 0..max_val
//   max_u()      larger of two unsigned values
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- 2-FF synchroniser, tick-driven debounce
// FSM, registered one-clk press pulse and debounced level.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat pulses while held).
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   tick     1-clk sample strobe; FSM only advances when high
//   btn_raw  asynchronous raw button, active-high
//   level    debounced level
//   pulse    1-clk pulse per accepted press (and per repeat)
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CNT    = 20
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CW = width_for(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync_q1;
  logic          sync;
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt;
  logic          pulse_nxt;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned HW = width_for(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          repeating, repeating_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      hold_cnt  <= '0;
      repeating <= 1'b0;
`endif
    end else begin
      sync_q1 <= btn_raw;
      sync    <= sync_q1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level   <= level_nxt;
      pulse   <= pulse_nxt;
`ifdef BTN_AUTO_REPEAT_EN
      hold_cnt  <= hold_cnt_nxt;
      repeating <= repeating_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    pulse_nxt = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    hold_cnt_nxt  = hold_cnt;
    repeating_nxt = repeating;
`endif
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (sync) begin
            // A single required sample means the first agreeing sample accepts.
            if (STABLE_CNT == 1) begin
              state_nxt = PRESSED;
              level_nxt = 1'b1;
              pulse_nxt = 1'b1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = PRESS_WAIT;
              cnt_nxt   = CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            level_nxt = 1'b1;
            pulse_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            if (STABLE_CNT == 1) begin
              state_nxt = IDLE;
              level_nxt = 1'b0;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE_WAIT;
              cnt_nxt   = CW'(1);
            end
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (hold_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
            pulse_nxt     = 1'b1;
            hold_cnt_nxt  = '0;
            repeating_nxt = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            level_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
`ifdef BTN_AUTO_REPEAT_EN
    // Hold timer lives only in PRESSED: clearing it whenever PRESSED is not the
    // next state both stops repeats on release and zeroes it for re-entry.
    if (state_nxt != PRESSED) begin
      hold_cnt_nxt  = '0;
      repeating_nxt = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: conditioning stage for the traffic-light controller's
// push-buttons. Shared sample-tick generator plus N_BTN debounce channels.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat pulses while held).
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   btn_raw    asynchronous raw buttons, active-high
//   btn_level  debounced level per button
//   btn_pulse  1-clk pulse per accepted press (and per repeat)
//   tick       1-clk sample strobe, every CLK_HZ/SAMPLE_HZ cycles
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned SAMPLE_HZ     = 1_000,
  parameter int unsigned STABLE_CNT    = 20,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             tick
);

  localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TW       = width_for(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || STABLE_CNT < 1 || STABLE_CNT > 255 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_debounce_pulse: invalid parameter set");
  end

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CNT   (STABLE_CNT)
`ifdef BTN_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .btn_raw(btn_raw[i]),
      .level  (btn_level[i]),
      .pulse  (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed self-checking bench for btn_debounce_pulse.
// TICK_DIV=10, STABLE_CNT=4, REPEAT_DELAY=6, REPEAT_PERIOD=3.
// Honours BTN_AUTO_REPEAT_EN for the hold-repeat expectations.
module tb_btn_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic       tick;

  btn_debounce_pulse #(
    .N_BTN        (4),
    .CLK_HZ       (1000),
    .SAMPLE_HZ    (100),
    .STABLE_CNT   (4),
    .REPEAT_DELAY (6),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts pulses, flags any pulse wider than 1 clk or not
  // directly following a tick cycle, logs tick numbers of channel-3 pulses.
  int         tick_num   = 0;
  int         pulse_cnt[4] = '{default: 0};
  int         width_err  = 0;
  int         timing_err = 0;
  logic [3:0] prev_pulse = '0;
  logic       prev_tick  = 1'b0;
  int         ch3_ticks[16];
  int         ch3_n      = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (btn_pulse[i] === 1'b1) begin
        pulse_cnt[i]++;
        if (prev_pulse[i]) width_err++;
        if (!prev_tick) timing_err++;
        if (i == 3 && ch3_n < 16) begin
          ch3_ticks[ch3_n] = tick_num;
          ch3_n++;
        end
      end
    end
    prev_pulse = btn_pulse;
    prev_tick  = (tick === 1'b1);
    if (tick === 1'b1) tick_num++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Advance to the negedge of the n-th upcoming tick cycle.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (tick !== 1'b1 && w < 40);
      if (tick !== 1'b1) check("tick_timeout", 32'd0, 32'd1);
    end
    #1;
  endtask

  int p;
  int n0;
  int first_tick;
  int exp_n;
  int exp_off[6];

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'hF;

    // 1: reset with all buttons high, then first tick 10 cycles after release
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", {23'd0, btn_level, btn_pulse, tick}, 32'd0);
    btn_raw    = 4'h0;
    rst_n      = 1'b1;
    first_tick = 0;
    check("rst_tick_c1", {31'd0, tick}, 32'd0);
    for (int c = 2; c <= 15; c++) begin
      @(negedge clk);
      if (tick === 1'b1 && first_tick == 0) first_tick = c;
    end
    #1;
    check("first_tick_cycle", first_tick, 10);

    // 2: clean press / release on channel 0
    p = pulse_cnt[0];
    ticks(1);
    btn_raw[0] = 1'b1;
    ticks(4);
    check("t2_before_pulse", {28'd0, btn_pulse}, 32'h0);
    cycles(1);
    check("t2_pulse", {28'd0, btn_pulse}, 32'h1);
    check("t2_level", {31'd0, btn_level[0]}, 32'd1);
    cycles(1);
    check("t2_width", {28'd0, btn_pulse}, 32'h0);
    ticks(3);
    check("t2_one_pulse", pulse_cnt[0], p + 1);
    btn_raw[0] = 1'b0;
    ticks(4);
    check("t2_level_held", {31'd0, btn_level[0]}, 32'd1);
    cycles(1);
    check("t2_level_released", {31'd0, btn_level[0]}, 32'd0);
    check("t2_no_release_pulse", pulse_cnt[0], p + 1);

    // 3: bounce on channel 1, toggling every 7 clk for 60 clk, then stays high
    p = pulse_cnt[1];
    for (int k = 0; k < 60; k++) begin
      btn_raw[1] = ((k / 7) % 2 == 0);
      cycles(1);
    end
    check("t3_bounce_pulses", pulse_cnt[1], p);
    check("t3_bounce_level", {31'd0, btn_level[1]}, 32'd0);
    btn_raw[1] = 1'b1;
    ticks(5);
    cycles(2);
    check("t3_settled_pulse", pulse_cnt[1], p + 1);
    check("t3_settled_level", {31'd0, btn_level[1]}, 32'd1);
    btn_raw[1] = 1'b0;
    ticks(5);
    cycles(1);
    check("t3_release_level", {31'd0, btn_level[1]}, 32'd0);

    // 4: 3-tick glitch rejected; 2-tick dip while pressed ignored
    p = pulse_cnt[2];
    ticks(1);
    btn_raw[2] = 1'b1;
    ticks(3);
    btn_raw[2] = 1'b0;
    ticks(3);
    cycles(1);
    check("t4_glitch_pulse", pulse_cnt[2], p);
    check("t4_glitch_level", {31'd0, btn_level[2]}, 32'd0);
    ticks(1);
    btn_raw[2] = 1'b1;
    ticks(4);
    cycles(1);
    check("t4_accept", {28'd0, btn_pulse}, 32'h4);
    ticks(1);
    btn_raw[2] = 1'b0;
    ticks(2);
    check("t4_dip_level_mid", {31'd0, btn_level[2]}, 32'd1);
    btn_raw[2] = 1'b1;
    ticks(3);
    cycles(1);
    check("t4_dip_level", {31'd0, btn_level[2]}, 32'd1);
    check("t4_dip_no_pulse", pulse_cnt[2], p + 1);
    btn_raw[2] = 1'b0;
    ticks(5);
    cycles(1);
    check("t4_release_level", {31'd0, btn_level[2]}, 32'd0);

    // 5a: simultaneous press on channels 2 and 3
    ticks(1);
    btn_raw = 4'b1100;
    ticks(4);
    check("t5_before", {28'd0, btn_pulse}, 32'h0);
    cycles(1);
    check("t5_simul_pulse", {28'd0, btn_pulse}, 32'hC);
    check("t5_simul_level", {28'd0, btn_level}, 32'hC);
    btn_raw = 4'b0000;
    ticks(5);
    cycles(1);
    check("t5_simul_release", {28'd0, btn_level}, 32'h0);

    // 5b: reset during PRESS_WAIT drops the press; a fresh 4-tick press is needed
    p = pulse_cnt[0];
    ticks(1);
    btn_raw[0] = 1'b1;
    ticks(2);
    rst_n = 1'b0;
    cycles(3);
    check("t5_rst_outputs", {23'd0, btn_level, btn_pulse, tick}, 32'd0);
    rst_n = 1'b1;
    ticks(3);
    cycles(2);
    check("t5_rst_no_pulse", pulse_cnt[0], p);
    check("t5_rst_level", {31'd0, btn_level[0]}, 32'd0);
    ticks(1);
    cycles(1);
    check("t5_rst_fresh_pulse", {28'd0, btn_pulse}, 32'h1);
    btn_raw[0] = 1'b0;
    ticks(5);
    cycles(1);

    // 6: long hold on channel 3 (auto-repeat when enabled)
`ifdef BTN_AUTO_REPEAT_EN
    exp_n   = 6;
    exp_off = '{0, 6, 9, 12, 15, 18};
`else
    exp_n   = 1;
    exp_off = '{0, 0, 0, 0, 0, 0};
`endif
    n0 = ch3_n;
    ticks(1);
    btn_raw[3] = 1'b1;
    ticks(4);
    cycles(1);
    check("t6_accept", {31'd0, btn_pulse[3]}, 32'd1);
    ticks(20);
    btn_raw[3] = 1'b0;
    check("t6_pulse_count", ch3_n - n0, exp_n);
    for (int k = 1; k < exp_n && n0 + k < ch3_n; k++) begin
      check($sformatf("t6_repeat_%0d", k), ch3_ticks[n0 + k] - ch3_ticks[n0], exp_off[k]);
    end
    ticks(5);
    cycles(1);
    check("t6_release_level", {31'd0, btn_level[3]}, 32'd0);
    check("t6_no_release_pulse", ch3_n - n0, exp_n);

    check("pulse_width", width_err, 0);
    check("pulse_after_tick", timing_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
